// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter sharing the single reg_file write port
// between the ALU (req0) and load (req1) result paths.
module reg_wb_arbiter #(
   parameter  int N = 8,
   parameter  int M = 32,
   localparam int A = $clog2(M)
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         hold,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [A-1:0] req0_addr,
   input  logic [N-1:0] req0_data,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [A-1:0] req1_addr,
   input  logic [N-1:0] req1_data,
   output logic [A-1:0] Rd,
   output logic [N-1:0] Wdata,
   output logic         w_enable,
   output logic         wr_src,
   output logic [7:0]   zero_drops
);

   logic         last_q, last_d;
   logic [A-1:0] rd_q, rd_d;
   logic [N-1:0] wd_q, wd_d;
   logic         wen_q, wen_d;
   logic         src_q, src_d;
   logic [7:0]   drops_q, drops_d;

   logic         arb_ok;
   logic         gnt0, gnt1, xfer;
   logic [A-1:0] sel_addr;
   logic [N-1:0] sel_data;
   logic         zero_hit;

   // last_q == 1 means req1 won last, so req0 has priority next
   assign arb_ok = n_reset & ~hold;
   assign gnt0   = arb_ok & req0_valid & (~req1_valid | last_q);
   assign gnt1   = arb_ok & req1_valid & (~req0_valid | ~last_q);
   assign xfer   = gnt0 | gnt1;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign sel_addr = gnt1 ? req1_addr : req0_addr;
   assign sel_data = gnt1 ? req1_data : req0_data;
   assign zero_hit = xfer & (sel_addr == '0);

   always_comb begin
      last_d  = last_q;
      rd_d    = rd_q;
      wd_d    = wd_q;
      src_d   = src_q;
      wen_d   = 1'b0;
      drops_d = drops_q;
      if (xfer) begin
         last_d = gnt1;
         rd_d   = sel_addr;
         wd_d   = sel_data;
         src_d  = gnt1;
         wen_d  = ~zero_hit;
      end
      if (zero_hit && drops_q != 8'hff) begin
         drops_d = drops_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         last_q  <= 1'b1;
         rd_q    <= '0;
         wd_q    <= '0;
         wen_q   <= 1'b0;
         src_q   <= 1'b0;
         drops_q <= '0;
      end else begin
         last_q  <= last_d;
         rd_q    <= rd_d;
         wd_q    <= wd_d;
         wen_q   <= wen_d;
         src_q   <= src_d;
         drops_q <= drops_d;
      end
   end

   assign Rd         = rd_q;
   assign Wdata      = wd_q;
   assign w_enable   = wen_q;
   assign wr_src     = src_q;
   assign zero_drops = drops_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter with a behavioural reg_file
// fed from the write port.
module tb_reg_wb_arbiter;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       hold;
   logic       req0_valid, req0_ready;
   logic [4:0] req0_addr;
   logic [7:0] req0_data;
   logic       req1_valid, req1_ready;
   logic [4:0] req1_addr;
   logic [7:0] req1_data;
   logic [4:0] Rd;
   logic [7:0] Wdata;
   logic       w_enable;
   logic       wr_src;
   logic [7:0] zero_drops;

   reg_wb_arbiter dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .hold       (hold),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .Rd         (Rd),
      .Wdata      (Wdata),
      .w_enable   (w_enable),
      .wr_src     (wr_src),
      .zero_drops (zero_drops)
   );

   always #5 clk = ~clk;

   logic [7:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk) if (w_enable) rf[Rd] <= Wdata;

   typedef struct packed {
      logic       wen;
      logic [4:0] rd;
      logic [7:0] wd;
      logic       src;
      logic [7:0] drops;
   } exp_t;

   exp_t sb[$];

   int n_chk = 0;
   int n_fail = 0;

   logic       m_last;
   logic [4:0] m_rd;
   logic [7:0] m_wd;
   logic       m_src;
   logic [7:0] m_drops;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_last  = 1'b1;
      m_rd    = '0;
      m_wd    = '0;
      m_src   = 1'b0;
      m_drops = '0;
      sb.delete();
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      #2;
      chk("rst_wen", w_enable, 0);
      chk("rst_rd", Rd, 0);
      chk("rst_wd", Wdata, 0);
      chk("rst_src", wr_src, 0);
      chk("rst_drops", zero_drops, 0);
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      #8;
      n_reset = 1'b1;
      model_reset();
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // one clock: check readies, push expected write, pop after the edge
   task automatic step();
      logic       e0, e1;
      logic [4:0] wa;
      exp_t       e;
      @(negedge clk);
      e0 = !hold && req0_valid && (!req1_valid || m_last);
      e1 = !hold && req1_valid && (!req0_valid || !m_last);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      e = '0;
      if (e0 || e1) begin
         wa     = e1 ? req1_addr : req0_addr;
         m_rd   = wa;
         m_wd   = e1 ? req1_data : req0_data;
         m_src  = e1;
         m_last = e1;
         e.wen  = (wa != 5'd0);
         if (wa == 5'd0 && m_drops != 8'd255) m_drops = m_drops + 8'd1;
      end
      e.rd    = m_rd;
      e.wd    = m_wd;
      e.src   = m_src;
      e.drops = m_drops;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("w_enable", w_enable, e.wen);
         chk("Rd", Rd, e.rd);
         chk("Wdata", Wdata, e.wd);
         chk("wr_src", wr_src, e.src);
         chk("zero_drops", zero_drops, e.drops);
      end
   endtask

   logic [3:0] srcs;
   logic [7:0] exp7;

   initial begin
      hold = 1'b0;
      req0_addr = '0; req0_data = '0;
      req1_addr = '0; req1_data = '0;
      idle();
      model_reset();
      do_reset();

      // reset then idle
      repeat (5) step();

      // single writer
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 5'd22; req0_data = 8'd133;
      step();
      idle();
      chk("single_src", wr_src, 0);
      chk("single_wen", w_enable, 1);
      step();
      step();
      chk("rf22", rf[22], 133);

      // contention starts from reset priority
      do_reset();
      req0_valid = 1'b1; req0_addr = 5'd1;  req0_data = 8'd33;
      req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 8'd233;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("cont_wen", w_enable, 1);
         srcs[i] = wr_src;
      end
      chk("cont_order", srcs, 4'b1010);

      // hold with both valid, then resume
      hold = 1'b1;
      repeat (3) step();
      hold = 1'b0;
      step();
      chk("resume_src", wr_src, 0);

      // same destination from both requesters
      req0_addr = 5'd7; req0_data = 8'd10;
      req1_addr = 5'd7; req1_data = 8'd20;
      step();
      step();
      exp7 = m_wd;
      idle();
      step();
      step();
      chk("rf7_final", rf[7], exp7);
      chk("rf7_later", rf[7], 10);

      // register 0 writes and saturation
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 8'd99;
      step();
      chk("drop_one", zero_drops, 1);
      chk("drop_wen", w_enable, 0);
      repeat (299) step();
      chk("drop_sat", zero_drops, 255);
      chk("rf0", rf[0], 0);
      idle();
      step();

      // reset while a write is in flight
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 8'd77;
      @(negedge clk);
      chk("mid_rdy0", req0_ready, 1);
      @(posedge clk); #1;
      chk("mid_wen", w_enable, 1);
      n_reset = 1'b0;
      #1;
      chk("mid_drop_wen", w_enable, 0);
      chk("mid_rd", Rd, 0);
      idle();
      @(posedge clk); #1;
      n_reset = 1'b1;
      model_reset();
      step();
      chk("rf5", rf[5], 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
